// File: rtl/if_fetch_unit_pkg.sv
// Core-wide fetch definitions: datapath width, reset PC, fetch FSM encoding
// and small PC helpers shared by the fetch front end.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_t;

  // Clear the byte-offset bits so fetch always targets a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs. Flush empties it
// in one cycle; storage is not reset, only the pointers and the occupancy.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DATA_W = 2 * XLEN,
  parameter int DEPTH  = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Entry storage: written on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; flush behaves like a reset of the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word fetches over a
// req/ack handshake, buffers {pc, instr} pairs for decode and handles
// redirects, abandoning an in-flight access by draining its ack.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            misalign_err
);

  localparam int CNT_W = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  fetch_state_t      state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   drain_addr;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [2*XLEN-1:0] fifo_rdata;
  logic [XLEN-1:0]   head_pc;
  logic [XLEN-1:0]   head_instr;

  // Request depends only on registered state and occupancy; reset forces it low.
  assign imem_req  = rst_n && ((state == ST_DRAIN) || !fifo_full);
  assign imem_addr = (state == ST_DRAIN) ? drain_addr : fetch_pc;

  // Only a genuine fetch that is not being redirected away lands in the buffer.
  assign fifo_push = (state == ST_FETCH) && imem_req && imem_ack && !redirect_valid;
  assign fifo_pop  = if_valid && if_ready;

  assign head_pc    = fifo_rdata[2*XLEN-1:XLEN];
  assign head_instr = fifo_rdata[XLEN-1:0];
  assign if_valid   = (fifo_count != '0);
  assign if_pc      = fifo_empty ? '0 : head_pc;
  assign if_instr   = fifo_empty ? '0 : head_instr;

  fetch_fifo #(
    .DATA_W (2 * XLEN),
    .DEPTH  (DEPTH)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata ({fetch_pc, imem_rdata}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Fetch FSM: PC advance, redirect handling and drain of an abandoned access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_FETCH;
      fetch_pc     <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      if (redirect_valid && is_misaligned(redirect_pc)) begin
        misalign_err <= 1'b1;
      end
      case (state)
        ST_FETCH: begin
          if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
            // An outstanding access cannot be withdrawn; remember it and wait for its ack.
            if (imem_req && !imem_ack) begin
              drain_addr <= fetch_pc;
              state      <= ST_DRAIN;
            end
          end else if (imem_req && imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        ST_DRAIN: begin
          if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
          end
          if (imem_ack) begin
            state <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a variable-latency memory model drives the fetch
// port, and a stream-level reference model tracks which PCs decode must see.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_err;

  if_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // counters
  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] exp_pc = RST_PC;      // next PC decode must receive
  logic [31:0] next_fetch = RST_PC;  // address the next new access must use
  int          occ = 0;              // instructions buffered and not yet consumed
  bit          mis = 1'b0;
  bit          after_rst = 1'b0;

  // memory model state
  bit          in_acc = 1'b0;
  bit          tainted = 1'b0;
  logic [31:0] acc_addr = '0;
  int          age = 0;
  int          cur_lat = 0;
  int          lat_mode = 0;         // <0: random latency 0..3 per access

  // observation
  int          n_ack = 0;
  int          n_start = 0;
  int          n_pop = 0;
  logic [31:0] last_pop_pc = '0;
  logic [31:0] last_start_addr = '0;
  bit          last_ack = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs, drive inputs, play memory, advance the model.
  task automatic step(input logic rstn, input logic rdy, input logic redir,
                      input logic [31:0] rpc);
    logic ack;
    logic pop;
    logic good;
    @(negedge clk);
    check("if_valid", 32'(if_valid), 32'(occ > 0));
    check("misalign_err", 32'(misalign_err), 32'(mis));
    if (after_rst) begin
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_instr", if_instr, 32'h0);
      after_rst = 1'b0;
    end
    pop = rstn && rdy && (occ > 0);
    if (pop) begin
      check("if_pc", if_pc, exp_pc);
      check("if_instr", if_instr, mem_word(exp_pc));
      last_pop_pc = if_pc;
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    rst_n = rstn;
    if_ready = rdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    #1;
    ack = 1'b0;
    if (!rstn) begin
      check("req_in_reset", 32'(imem_req), 32'd0);
      in_acc = 1'b0;
    end else if (imem_req) begin
      if (!in_acc) begin
        check("fetch_addr", imem_addr, next_fetch);
        check("req_not_full", 32'(occ < DEPTH), 32'd1);
        in_acc = 1'b1;
        tainted = 1'b0;
        acc_addr = imem_addr;
        age = 0;
        cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        last_start_addr = imem_addr;
        n_start++;
      end else begin
        check("addr_stable", imem_addr, acc_addr);
      end
      ack = (age == cur_lat);
      age++;
    end else if (in_acc) begin
      check("req_held", 32'(imem_req), 32'd1);
    end
    imem_ack = ack;
    imem_rdata = ack ? mem_word(acc_addr) : $urandom;
    last_ack = ack;
    // posedge effects
    if (!rstn) begin
      occ = 0;
      exp_pc = RST_PC;
      next_fetch = RST_PC;
      mis = 1'b0;
      after_rst = 1'b1;
    end else begin
      good = ack && !tainted;
      if (ack) begin
        in_acc = 1'b0;
        n_ack++;
      end
      if (redir) begin
        if (rpc[1:0] != 2'b00) mis = 1'b1;
        exp_pc = {rpc[31:2], 2'b00};
        next_fetch = exp_pc;
        occ = 0;
        if (in_acc) tainted = 1'b1;
      end else begin
        if (good) begin
          occ++;
          next_fetch = acc_addr + 32'd4;
        end
        if (pop) occ--;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Run with decode ready until one more instruction is consumed.
  task automatic wait_pop(input string tag);
    int p0;
    p0 = n_pop;
    for (int i = 0; i < 30 && n_pop == p0; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check(tag, 32'(n_pop != p0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int p0;
    int a0;
    int s0;
    logic [31:0] rpc;
    @(posedge clk);

    // reset then zero-wait streaming
    lat_mode = 0;
    do_reset(2);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    p0 = n_pop;
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("stream_rate", 32'(n_pop - p0), 32'd10);

    // backpressure
    do_reset(2);
    a0 = n_ack;
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("bp_acks", 32'(n_ack - a0), 32'd2);
    check("bp_req_low", 32'(imem_req), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("bp_first_pc", last_pop_pc, 32'h3000);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // redirect with an access in flight
    lat_mode = 3;
    do_reset(2);
    last_start_addr = '0;
    for (int i = 0; i < 40 && last_start_addr != 32'h3008; i++)
      step(1'b1, 1'b1, 1'b0, 32'h0);
    check("inflight_start", last_start_addr, 32'h3008);
    step(1'b1, 1'b1, 1'b1, 32'h3100);
    s0 = n_start;
    for (int i = 0; i < 20 && n_start == s0; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("inflight_next_req", last_start_addr, 32'h3100);
    wait_pop("inflight_pop_seen");
    check("inflight_first_pc", last_pop_pc, 32'h3100);

    // redirect coincident with ack and pop
    lat_mode = 0;
    do_reset(2);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h4000);
    check("coinc_pop_pc", last_pop_pc, 32'h3008);
    check("coinc_ack", 32'(last_ack), 32'd1);
    check("coinc_ack_addr", acc_addr, 32'h300C);
    wait_pop("coinc_pop_seen");
    check("coinc_next_pc", last_pop_pc, 32'h4000);

    // misaligned redirect
    step(1'b1, 1'b1, 1'b1, 32'h3102);
    wait_pop("mis_pop_seen");
    check("mis_pc", last_pop_pc, 32'h3100);
    check("mis_flag", 32'(misalign_err), 32'd1);
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);

    // wrap-around
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    s0 = n_start;
    for (int i = 0; i < 20 && (n_start - s0) < 2; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_addr", last_start_addr, 32'h0000_0000);
    wait_pop("wrap_pop_seen");
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("mis_sticky", 32'(misalign_err), 32'd1);
    do_reset(1);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // randomized traffic with variable memory latency
    lat_mode = -1;
    for (int i = 0; i < 900; i++) begin
      logic rstn;
      logic rdy;
      logic redir;
      rstn  = ($urandom_range(0, 199) != 0);
      rdy   = ($urandom_range(0, 9) < 7);
      redir = rstn && ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: rpc = RST_PC + 32'($urandom_range(0, 63)) * 32'd4;
        1: rpc = $urandom & 32'hFFFF_FFFC;
        2: rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = $urandom;
      endcase
      step(rstn, rdy, redir, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
